// File: rtl/alu_pkg.sv
// alu_pkg: shared widths, function-select codes and FSM states for the arbitrated ALU
package alu_pkg;
  localparam int OP_W = 4;
  localparam int RES_W = 8;
  localparam logic [1:0] FSEL_ADD = 2'b00;
  localparam logic [1:0] FSEL_SUB = 2'b01;
  localparam logic [1:0] FSEL_MUL = 2'b10;
  localparam logic [1:0] FSEL_XOR = 2'b11;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
endpackage

// File: rtl/alu_core.sv
// alu_core: registered 4-bit ALU (add, sub, mul, xor) with an 8-bit result and one cycle of latency
module alu_core
  import alu_pkg::*;
(
  input  logic             Clk,
  input  logic             Rst,
  input  logic [OP_W-1:0]  A,
  input  logic [OP_W-1:0]  B,
  input  logic [1:0]       Fsel,
  output logic [RES_W-1:0] Y
);
  logic [RES_W-1:0] a_x, b_x;
  assign a_x = RES_W'(A);
  assign b_x = RES_W'(B);
  always_ff @(posedge Clk)
    if (Rst) Y <= '0;
    else Y <= Fsel == FSEL_ADD ? a_x + b_x :
              Fsel == FSEL_SUB ? a_x - b_x :
              Fsel == FSEL_MUL ? a_x * b_x : a_x ^ b_x;
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter sharing one registered ALU among N_REQ requesters
// Define ALU_ARB_FIXED_PRI_EN for fixed lowest-index-wins priority instead of round-robin.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W = $clog2(N_REQ)
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [N_REQ-1:0]      Req,
  input  logic [4*N_REQ-1:0]    A_in,
  input  logic [4*N_REQ-1:0]    B_in,
  input  logic [2*N_REQ-1:0]    Fsel_in,
  output logic [N_REQ-1:0]      Gnt,
  output logic                  Busy,
  output logic                  Res_Valid,
  output logic [ID_W-1:0]       Res_Id,
  output logic [RES_W-1:0]      O
);
  state_t state;
  logic [ID_W-1:0] win, id;
  logic [OP_W-1:0] a_q, b_q;
  logic [1:0] f_q;
`ifdef ALU_ARB_FIXED_PRI_EN
  always_comb begin
    win = '0;
    for (int k = N_REQ - 1; k >= 0; k--)
      if (Req[k]) win = ID_W'(k);
  end
`else
  logic [ID_W-1:0] rr;
  // scan downwards so the candidate closest to rr is the last (winning) assignment
  always_comb begin
    win = '0;
    for (int k = N_REQ - 1; k >= 0; k--)
      if (Req[(int'(rr) + k) % N_REQ]) win = ID_W'((int'(rr) + k) % N_REQ);
  end
  always_ff @(posedge Clk)
    if (Rst) rr <= '0;
    else if (state == IDLE && |Req) rr <= int'(win) == N_REQ - 1 ? '0 : win + 1'b1;
`endif
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= IDLE;
      Gnt <= '0;
      Busy <= 1'b0;
      Res_Valid <= 1'b0;
      Res_Id <= '0;
      id <= '0;
      a_q <= '0;
      b_q <= '0;
      f_q <= '0;
    end else begin
      Gnt <= '0;
      Res_Valid <= 1'b0;
      case (state)
        IDLE: if (|Req) begin
          state <= EXEC;
          id <= win;
          a_q <= A_in[OP_W*win +: OP_W];
          b_q <= B_in[OP_W*win +: OP_W];
          f_q <= Fsel_in[2*win +: 2];
          Gnt <= N_REQ'(1) << win;
          Busy <= 1'b1;
        end
        EXEC: begin
          state <= RESP;
          Res_Valid <= 1'b1;
          Res_Id <= id;
        end
        RESP: begin
          state <= IDLE;
          Busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
  // operand latches only move on a grant, so O holds between responses
  alu_core u_core (
    .Clk(Clk),
    .Rst(Rst),
    .A(a_q),
    .B(b_q),
    .Fsel(f_q),
    .Y(O)
  );
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and randomized checks of alu_arbiter against a behavioural model
module tb_alu_arbiter;
  localparam int N = 4;
  logic Clk = 1'b0, Rst = 1'b1;
  logic [N-1:0] Req = '0;
  logic [4*N-1:0] A_in = '0, B_in = '0;
  logic [2*N-1:0] Fsel_in = '0;
  logic [N-1:0] Gnt;
  logic Busy, Res_Valid;
  logic [1:0] Res_Id;
  logic [7:0] O;
  int vecs = 0, errs = 0, rr_m = 0;
  logic [7:0] last_o = '0;
  int last_id = 0;

  alu_arbiter #(.N_REQ(N)) dut (
    .Clk(Clk), .Rst(Rst), .Req(Req), .A_in(A_in), .B_in(B_in), .Fsel_in(Fsel_in),
    .Gnt(Gnt), .Busy(Busy), .Res_Valid(Res_Valid), .Res_Id(Res_Id), .O(O)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] rq);
`ifdef ALU_ARB_FIXED_PRI_EN
    for (int k = 0; k < N; k++) if (rq[k]) return k;
`else
    for (int k = 0; k < N; k++) if (rq[(rr_m + k) % N]) return (rr_m + k) % N;
`endif
    return -1;
  endfunction

  function automatic logic [7:0] alu_ref(input int a, input int b, input int f);
    int r;
    r = f == 0 ? a + b : f == 1 ? a - b : f == 2 ? a * b : a ^ b;
    return 8'(r & 255);
  endfunction

  task automatic do_reset(input int cycles);
    Rst = 1'b1;
    repeat (cycles) begin
      Req = N'($urandom);
      @(posedge Clk); #1;
      chk("rst_gnt", 32'(Gnt), 0);
      chk("rst_busy", 32'(Busy), 0);
      chk("rst_valid", 32'(Res_Valid), 0);
      chk("rst_id", 32'(Res_Id), 0);
      chk("rst_o", 32'(O), 0);
    end
    Rst = 1'b0;
    rr_m = 0;
    last_o = '0;
    last_id = 0;
  endtask

  task automatic op(input logic [N-1:0] rq, input logic [4*N-1:0] a, input logic [4*N-1:0] b,
                    input logic [2*N-1:0] f);
    int w;
    logic [7:0] e;
    Req = rq; A_in = a; B_in = b; Fsel_in = f;
    w = pick(rq);
    @(posedge Clk); #1;
    Req = N'($urandom); A_in = 16'($urandom); B_in = 16'($urandom); Fsel_in = 8'($urandom);
    if (w < 0) begin
      chk("idle_gnt", 32'(Gnt), 0);
      chk("idle_busy", 32'(Busy), 0);
      chk("idle_o", 32'(O), 32'(last_o));
      return;
    end
    e = alu_ref(int'(a[4*w +: 4]), int'(b[4*w +: 4]), int'(f[2*w +: 2]));
`ifndef ALU_ARB_FIXED_PRI_EN
    rr_m = (w + 1) % N;
`endif
    chk("exec_gnt", 32'(Gnt), 32'(1) << w);
    chk("exec_busy", 32'(Busy), 1);
    chk("exec_valid", 32'(Res_Valid), 0);
    @(posedge Clk); #1;
    chk("resp_valid", 32'(Res_Valid), 1);
    chk("resp_id", 32'(Res_Id), 32'(w));
    chk("resp_o", 32'(O), 32'(e));
    chk("resp_busy", 32'(Busy), 1);
    chk("resp_gnt", 32'(Gnt), 0);
    last_o = e;
    last_id = w;
    @(posedge Clk); #1;
    chk("back_valid", 32'(Res_Valid), 0);
    chk("back_busy", 32'(Busy), 0);
    chk("back_o", 32'(O), 32'(last_o));
    chk("back_id", 32'(Res_Id), 32'(last_id));
  endtask

  initial begin
    do_reset(2);
    op(4'b0110, 16'h0230, 16'h0150, 8'b0000_0000);
    op(4'b0001, 16'h0009, 16'h0007, 8'b0000_0000);
    op(4'b0100, 16'h0300, 16'h0500, 8'b0001_0000);
    op(4'b0100, 16'h0F00, 16'h0F00, 8'b0010_0000);
    op(4'b0100, 16'h0A00, 16'h0500, 8'b0011_0000);
    op(4'b0100, 16'h0F00, 16'h0F00, 8'b0000_0000);
    do_reset(1);
    for (int i = 0; i < 5; i++) op(4'b1111, 16'h4321, 16'h5678, 8'b1110_0100);
    Req = 4'b0010; A_in = 16'h0070; B_in = 16'h0030; Fsel_in = 8'b0000_1000;
    @(posedge Clk); #1;
    chk("abort_gnt", 32'(Gnt), 32'b0010);
    Rst = 1'b1;
    @(posedge Clk); #1;
    chk("abort_valid", 32'(Res_Valid), 0);
    chk("abort_busy", 32'(Busy), 0);
    Rst = 1'b0; Req = 4'b0000; rr_m = 0; last_o = '0; last_id = 0;
    @(posedge Clk); #1;
    chk("abort_novalid", 32'(Res_Valid), 0);
    op(4'b1010, 16'h0070, 16'h0030, 8'b0000_1000);
    for (int i = 0; i < 4; i++) op(4'b1010, 16'($urandom), 16'($urandom), 8'($urandom));
    for (int i = 0; i < 60; i++) op(N'($urandom), 16'($urandom), 16'($urandom), 8'($urandom));
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one registered 4-bit ALU (add, subtract, multiply, xor; 8-bit result) among `N_REQ` requesters. Each requester raises a request with its operands and function select. The block grants one requester at a time, round-robin, runs the operation, and returns the tagged result. It sits between the requesting datapath units and the ALU core, and is the only path into that core.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters, 2..8.
- `ID_W`, default `$clog2(N_REQ)`: width of the result tag.

Ports:
- `Clk` input, 1 bit: the single clock; all state changes on the rising edge.
- `Rst` input, 1 bit: reset, synchronous and active-high.
- `Req` input, `N_REQ` bits: request per requester, level-sensitive.
- `A_in` input, `4*N_REQ` bits: operand A; requester i uses slice `[4i+3:4i]`.
- `B_in` input, `4*N_REQ` bits: operand B, sliced the same way.
- `Fsel_in` input, `2*N_REQ` bits: function select; requester i uses slice `[2i+1:2i]`.
- `Gnt` output, `N_REQ` bits: one-hot grant pulse, one cycle long.
- `Busy` output, 1 bit: high while an operation is in flight.
- `Res_Valid` output, 1 bit: one-cycle pulse when the result is on `O`.
- `Res_Id` output, `ID_W` bits: index of the requester that owns the current result.
- `O` output, 8 bits: ALU result.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: if `Req` is nonzero, pick winner i, latch slices i of `A_in`, `B_in` and `Fsel_in`, then go to EXEC. Otherwise stay in IDLE.
- EXEC: `Gnt[i]`=1 and `Busy`=1. The ALU core registers the result at the end of this cycle. Always go to RESP.
- RESP: `Res_Valid`=1, `Res_Id`=i, `O`=result, `Busy`=1. Always return to IDLE.
- `Req` is sampled only in IDLE; changes during EXEC or RESP are ignored.
- A request dropped before it is sampled is simply withdrawn.
- A requester still holding `Req` when the FSM returns to IDLE is treated as a new request.
- Arbitration is round-robin from pointer `rr`. Candidates are searched `rr`, `rr+1`, … modulo `N_REQ`. After a grant to i, `rr` becomes `(i+1) mod N_REQ`; it wraps from `N_REQ-1` to 0.
- Fsel encoding:
  - 00: A+B, zero-extended.
  - 01: A−B, computed at 8 bits modulo 256 (3−5 = 0xFE).
  - 10: A×B, 8 bits, no overflow possible.
  - 11: A^B, zero-extended.
- `O` and `Res_Id` hold their last values after RESP until the next RESP.

Reset values (`Rst`=1 at a rising edge):
- state IDLE, `rr`=0.
- `Gnt`=0, `Busy`=0, `Res_Valid`=0, `Res_Id`=0, `O`=0x00.

Reset in EXEC or RESP aborts the operation: no `Res_Valid` pulse follows, and the aborted requester must re-request.

## Timing
- Edge t samples `Req` and the operands in IDLE.
- `Gnt[i]` is high during cycle t+1.
- `Res_Valid` and `O` are valid during cycle t+2.
- The earliest next sample is edge t+3, so sustained throughput is one operation per 3 cycles.
- Operands need only be stable at edge t. The requester may change them from cycle t+1 onward.
- All outputs are registered; there is no combinational path from input to output.

## Configuration
- `ALU_ARB_FIXED_PRI_EN` defined: fixed priority. The lowest-index active request always wins and `rr` is not used. A continuously requesting low index can starve higher indices; this is accepted.
- Not defined: round-robin as described in Operation.

## Structure
- Package `alu_pkg` holds:
  - Fsel constants `FSEL_ADD`=2'b00, `FSEL_SUB`=2'b01, `FSEL_MUL`=2'b10, `FSEL_XOR`=2'b11.
  - The FSM state enum (IDLE, EXEC, RESP).
  - Operand width 4 and result width 8.
- One sub-module, `alu_core`: registered ALU taking A, B and Fsel, producing an 8-bit result, with one cycle of latency. It uses the same synchronous active-high `Rst` and resets its result to 0.
- Arbitration, the operand latches and the FSM live in `alu_arbiter`.

## Test plan
- Reset: hold `Rst` for 2 cycles with random `Req` → all outputs 0, no `Gnt` asserted, and the first grant after reset goes to the lowest active index.
- Single requester: `Req`=0001, A0=9, B0=7, Fsel0=00 at edge t → `Gnt`=0001 in cycle t+1; `Res_Valid`=1, `O`=0x10, `Res_Id`=0 in cycle t+2.
- Arithmetic corners through requester 2, expecting `Res_Id`=2 each time:
  - 3−5 → 0xFE.
  - 15×15 → 0xE1.
  - 0xA^0x5 → 0x0F.
  - 15+15 → 0x1E.
- Contention: `Req`=1111 held continuously → grants 0,1,2,3,0 at 3-cycle spacing, and `Res_Id` matches each grant.
- Abort: assert `Rst` during EXEC of a requester-1 operation → no `Res_Valid` pulse; after release with `Req`=1010 the grant goes to 1.
- With `ALU_ARB_FIXED_PRI_EN` and `Req`=1010 held → every grant goes to requester 1; requester 3 is never granted.
